// File: rtl/multi_string_comparator.sv
// Multi-pattern byte-string scanner for the packet-inspection path.
// Holds NUM_PAT programmable patterns and checks every byte alignment of the
// payload stream, including matches spanning word boundaries. Payload is
// forwarded through a DELAY-cycle pipe and match flags are delayed to line
// up with the word that completed the match.
module multi_string_comparator #(
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 17,
  parameter int NUM_PAT = 4,
  parameter int DELAY   = 5,
  localparam int IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   data_valid,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   pat_wr_en,
  input  logic [IDX_W-1:0]       pat_wr_idx,
  input  logic [MAX_LEN*8-1:0]   pat_wr_data,
  input  logic [LEN_W-1:0]       pat_wr_len,
  input  logic [NUM_PAT-1:0]     pat_enable,
  output logic [DATA_W-1:0]      data_out,
  output logic                   data_out_valid,
  output logic                   match,
  output logic [NUM_PAT-1:0]     match_vec,
  output logic [IDX_W-1:0]       match_idx,
  output logic [15:0]            match_count
);

  localparam int BPW    = DATA_W / 8;
  localparam int HIST   = MAX_LEN + BPW - 1;
  // Only the last MAX_LEN-1 bytes can contribute to a match that ends in the
  // next word, so that is all the storage kept; the current word completes
  // the HIST-byte search window.
  localparam int HBYTES = MAX_LEN - 1;
  localparam int FILL_W = $clog2(HIST + 1);
  localparam int HD     = (DELAY > 1) ? DELAY - 1 : 1;

  logic [MAX_LEN*8-1:0] pat_data [NUM_PAT];
  logic [LEN_W-1:0]     pat_len  [NUM_PAT];

  logic [HBYTES*8-1:0]  hist;
  logic [FILL_W-1:0]    fill;
  logic [HIST*8-1:0]    window;
  logic                 accept;

  logic [NUM_PAT-1:0]   hit_now;
  logic [NUM_PAT-1:0]   hit_pipe [HD];
  logic [NUM_PAT-1:0]   hit_aligned;

  logic [DATA_W-1:0]    data_pipe [DELAY];
  logic [DELAY-1:0]     valid_pipe;

  logic [NUM_PAT-1:0]   match_vec_nxt;

  assign accept = data_valid && !clear;
  assign window = {hist, data_in};

  // Pattern table: a write takes effect for words accepted from the next cycle.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int s = 0; s < NUM_PAT; s++) begin
        pat_data[s] <= '0;
        pat_len[s]  <= '0;
      end
    end else if (pat_wr_en && (int'(pat_wr_idx) < NUM_PAT)) begin
      pat_data[pat_wr_idx] <= pat_wr_data;
      pat_len[pat_wr_idx]  <= pat_wr_len;
    end
  end

  // Byte history and fill count; the newest byte lives at [7:0].
  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (data_valid) begin
      hist <= window[HBYTES*8-1:0];
      if (int'(fill) + BPW >= HIST) fill <= FILL_W'(HIST);
      else                          fill <= fill + FILL_W'(BPW);
    end
  end

  // Per-slot detection at every byte position b of the accepted word. A hit
  // ending at b needs len bytes actually received up to and including b.
  always_comb begin
    hit_now = '0;
    for (int s = 0; s < NUM_PAT; s++) begin
      for (int b = 0; b < BPW; b++) begin
        logic ok;
        ok = accept && pat_enable[s] && (pat_len[s] != '0) &&
             (int'(pat_len[s]) <= MAX_LEN) &&
             (int'(fill) + b + 1 >= int'(pat_len[s]));
        for (int k = 0; k < MAX_LEN; k++) begin
          if ((k < int'(pat_len[s])) &&
              (window[(BPW-1-b+k)*8 +: 8] != pat_data[s][k*8 +: 8]))
            ok = 1'b0;
        end
        if (ok) hit_now[s] = 1'b1;
      end
    end
  end

  // Alignment pipe for hits; clear drops everything in flight.
  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      for (int i = 0; i < HD; i++) hit_pipe[i] <= '0;
    end else begin
      hit_pipe[0] <= hit_now;
      for (int i = 1; i < HD; i++) hit_pipe[i] <= hit_pipe[i-1];
    end
  end

  generate
    if (DELAY == 1) begin : g_no_pipe
      assign hit_aligned = hit_now;
    end else begin : g_pipe
      assign hit_aligned = hit_pipe[DELAY-2];
    end
  endgenerate

  // Payload forwarding pipe; unaffected by clear.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < DELAY; i++) data_pipe[i] <= '0;
      valid_pipe <= '0;
    end else begin
      data_pipe[0]  <= data_in;
      valid_pipe[0] <= data_valid;
      for (int i = 1; i < DELAY; i++) begin
        data_pipe[i]  <= data_pipe[i-1];
        valid_pipe[i] <= valid_pipe[i-1];
      end
    end
  end

  assign data_out       = data_pipe[DELAY-1];
  assign data_out_valid = valid_pipe[DELAY-1];

  // Sticky update: a write to a slot wins over an aligned hit on that slot.
  always_comb begin
    match_vec_nxt = match_vec | hit_aligned;
    if (pat_wr_en && (int'(pat_wr_idx) < NUM_PAT))
      match_vec_nxt[pat_wr_idx] = 1'b0;
  end

  // Sticky flags and saturating per-word event counter; clear wins.
  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      match_vec   <= '0;
      match_count <= '0;
    end else begin
      match_vec <= match_vec_nxt;
      if ((|hit_aligned) && (match_count != 16'hFFFF))
        match_count <= match_count + 16'd1;
    end
  end

  // Lowest set bit of match_vec, 0 when none.
  always_comb begin
    match_idx = '0;
    for (int s = NUM_PAT - 1; s >= 0; s--) begin
      if (match_vec[s]) match_idx = IDX_W'(s);
    end
  end

  assign match = |match_vec;

endmodule

// File: tb/tb_multi_string_comparator.sv
// Self-checking bench for multi_string_comparator: a table-driven boundary
// spanning stream, hand-written corner sequences and a randomized run
// checked against a queue-based behavioural model.
module tb_multi_string_comparator;

  localparam int DATA_W  = 32;
  localparam int MAX_LEN = 17;
  localparam int NUM_PAT = 4;
  localparam int DELAY   = 5;
  localparam int BPW     = DATA_W / 8;

  logic                 clk;
  logic                 n_rst;
  logic                 clear;
  logic                 data_valid;
  logic [DATA_W-1:0]    data_in;
  logic                 pat_wr_en;
  logic [1:0]           pat_wr_idx;
  logic [MAX_LEN*8-1:0] pat_wr_data;
  logic [4:0]           pat_wr_len;
  logic [NUM_PAT-1:0]   pat_enable;
  logic [DATA_W-1:0]    data_out;
  logic                 data_out_valid;
  logic                 match;
  logic [NUM_PAT-1:0]   match_vec;
  logic [1:0]           match_idx;
  logic [15:0]          match_count;

  multi_string_comparator #(
    .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .NUM_PAT(NUM_PAT), .DELAY(DELAY)
  ) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .data_valid(data_valid),
    .data_in(data_in), .pat_wr_en(pat_wr_en), .pat_wr_idx(pat_wr_idx),
    .pat_wr_data(pat_wr_data), .pat_wr_len(pat_wr_len), .pat_enable(pat_enable),
    .data_out(data_out), .data_out_valid(data_out_valid), .match(match),
    .match_vec(match_vec), .match_idx(match_idx), .match_count(match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_model = 1'b1;

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [DATA_W-1:0]  d;
    logic               v;
    logic [NUM_PAT-1:0] h;
  } pipe_t;

  logic [7:0]           m_hist [$];
  logic [MAX_LEN*8-1:0] m_pat  [NUM_PAT];
  int                   m_len  [NUM_PAT];
  pipe_t                m_pipe [$];
  logic [NUM_PAT-1:0]   m_vec;
  int                   m_cnt;
  logic [DATA_W-1:0]    e_dout;
  logic                 e_dov;

  function automatic int lowest(input logic [NUM_PAT-1:0] v);
    for (int s = 0; s < NUM_PAT; s++) if (v[s]) return s;
    return 0;
  endfunction

  // Predict the effect of the coming clock edge from the current inputs.
  task automatic model_update();
    pipe_t ent, out;
    logic [NUM_PAT-1:0] hv;
    hv = '0;
    if (!n_rst) begin
      m_hist.delete();
      m_pipe.delete();
      for (int s = 0; s < NUM_PAT; s++) begin m_pat[s] = '0; m_len[s] = 0; end
      for (int i = 0; i < DELAY - 1; i++) begin
        ent.d = '0; ent.v = 1'b0; ent.h = '0; m_pipe.push_back(ent);
      end
      m_vec = '0; m_cnt = 0; e_dout = '0; e_dov = 1'b0;
      return;
    end
    if (data_valid && !clear) begin
      for (int i = 0; i < BPW; i++) m_hist.push_back(data_in[DATA_W-1-8*i -: 8]);
      while (m_hist.size() > 40) void'(m_hist.pop_front());
      for (int s = 0; s < NUM_PAT; s++) begin
        int len;
        len = m_len[s];
        if (pat_enable[s] && len >= 1 && len <= MAX_LEN) begin
          for (int b = 0; b < BPW; b++) begin
            int e;
            bit ok;
            e = m_hist.size() - BPW + b;
            if (e + 1 >= len) begin
              ok = 1'b1;
              for (int k = 0; k < len; k++)
                if (m_hist[e - len + 1 + k] != m_pat[s][(len-1-k)*8 +: 8]) ok = 1'b0;
              if (ok) hv[s] = 1'b1;
            end
          end
        end
      end
    end
    if (clear) m_hist.delete();
    ent.d = data_in; ent.v = data_valid; ent.h = hv;
    m_pipe.push_back(ent);
    out = m_pipe.pop_front();
    e_dout = out.d;
    e_dov  = out.v;
    if (clear) begin
      foreach (m_pipe[i]) m_pipe[i].h = '0;
      m_vec = '0;
      m_cnt = 0;
    end else begin
      m_vec = m_vec | out.h;
      if (out.h != '0 && m_cnt < 65535) m_cnt++;
    end
    if (pat_wr_en) begin
      m_vec[pat_wr_idx] = 1'b0;
      m_pat[pat_wr_idx] = pat_wr_data;
      m_len[pat_wr_idx] = int'(pat_wr_len);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("m_data_out", 64'(data_out), 64'(e_dout));
    check("m_data_out_valid", 64'(data_out_valid), 64'(e_dov));
    check("m_match_vec", 64'(match_vec), 64'(m_vec));
    check("m_match", 64'(match), 64'(|m_vec));
    check("m_match_idx", 64'(match_idx), 64'(lowest(m_vec)));
    check("m_match_count", 64'(match_count), 64'(m_cnt));
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    if (chk_model) compare_model();
    pat_wr_en = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic drive(input logic dv, input logic [DATA_W-1:0] d);
    data_valid = dv;
    data_in    = d;
    step();
  endtask

  task automatic write_pat(input int idx, input logic [MAX_LEN*8-1:0] p, input int len);
    data_valid  = 1'b0;
    data_in     = '0;
    pat_wr_en   = 1'b1;
    pat_wr_idx  = 2'(idx);
    pat_wr_data = p;
    pat_wr_len  = 5'(len);
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    drive(1'b0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic               dv;
    logic [DATA_W-1:0]  din;
    logic [DATA_W-1:0]  e_dout;
    logic               e_dov;
    logic [NUM_PAT-1:0] e_vec;
    logic [1:0]         e_idx;
    logic [15:0]        e_cnt;
  } vec_t;

  vec_t tbl [11];
  logic [DATA_W-1:0] words [6];

  initial begin
    words[0] = "Host"; words[1] = ": ww"; words[2] = "w.pu";
    words[3] = "rdue"; words[4] = ".edu"; words[5] = "\r\n\r\n";
    for (int r = 0; r < 11; r++) begin
      tbl[r].dv    = (r < 6);
      tbl[r].din   = (r < 6) ? words[r] : '0;
      tbl[r].e_dov = (r >= 4 && r < 10);
      tbl[r].e_dout = (r >= 4 && r < 10) ? words[r-4] : '0;
      tbl[r].e_vec = (r == 7) ? 4'b0100 : (r >= 8) ? 4'b0101 : 4'b0000;
      tbl[r].e_idx = (r == 7) ? 2'd2 : 2'd0;
      tbl[r].e_cnt = (r == 7) ? 16'd1 : (r >= 8) ? 16'd2 : 16'd0;
    end

    n_rst = 1'b0; clear = 1'b0; data_valid = 1'b1; data_in = '0;
    pat_wr_en = 1'b0; pat_wr_idx = '0; pat_wr_data = '0; pat_wr_len = '0;
    pat_enable = '0;

    // Reset held two cycles with traffic present.
    for (int i = 0; i < 2; i++) begin
      data_in = $urandom;
      step();
      check("rst_data_out", 64'(data_out), 64'd0);
      check("rst_data_out_valid", 64'(data_out_valid), 64'd0);
      check("rst_match", 64'(match), 64'd0);
      check("rst_match_vec", 64'(match_vec), 64'd0);
      check("rst_match_idx", 64'(match_idx), 64'd0);
      check("rst_match_count", 64'(match_count), 64'd0);
    end
    n_rst = 1'b1;
    for (int i = 0; i < DELAY; i++) begin
      data_valid = 1'b1;
      data_in = $urandom;
      step();
      check("rel_data_out_valid", 64'(data_out_valid), (i == DELAY - 1) ? 64'd1 : 64'd0);
    end

    // Boundary-spanning and multi-pattern stream from the table.
    write_pat(0, "www.purdue.edu", 14);
    write_pat(2, "purdue", 6);
    pat_enable = 4'b0101;
    do_clear();
    idle(4);
    for (int r = 0; r < 11; r++) begin
      drive(tbl[r].dv, tbl[r].din);
      check("tbl_data_out", 64'(data_out), 64'(tbl[r].e_dout));
      check("tbl_data_out_valid", 64'(data_out_valid), 64'(tbl[r].e_dov));
      check("tbl_match_vec", 64'(match_vec), 64'(tbl[r].e_vec));
      check("tbl_match", 64'(match), 64'(tbl[r].e_vec != 0));
      check("tbl_match_idx", 64'(match_idx), 64'(tbl[r].e_idx));
      check("tbl_match_count", 64'(match_count), 64'(tbl[r].e_cnt));
    end

    // Fill qualification: four zero bytes match a fresh zero word, five do not.
    pat_enable = 4'b0010;
    write_pat(1, '0, 4);
    do_clear();
    drive(1'b1, '0);
    idle(DELAY - 2);
    check("fill4_before", 64'(match_vec[1]), 64'd0);
    idle(1);
    check("fill4_match", 64'(match_vec[1]), 64'd1);
    write_pat(1, '0, 5);
    check("wr_clears_bit", 64'(match_vec[1]), 64'd0);
    do_clear();
    drive(1'b1, '0);
    idle(DELAY + 1);
    check("fill5_nomatch", 64'(match_vec), 64'd0);

    // Clear on the completing word: no match, payload still forwarded.
    pat_enable = 4'b0001;
    do_clear();
    for (int i = 0; i < 4; i++) drive(1'b1, words[i]);
    clear = 1'b1;
    drive(1'b1, words[4]);
    drive(1'b1, words[5]);
    idle(DELAY - 2);
    check("clr_data_out", 64'(data_out), 64'(words[4]));
    check("clr_data_out_valid", 64'(data_out_valid), 64'd1);
    idle(DELAY);
    check("clr_match_vec", 64'(match_vec), 64'd0);
    check("clr_match_count", 64'(match_count), 64'd0);
    drive(1'b1, "www.");
    drive(1'b1, "purd");
    drive(1'b1, "ue.e");
    drive(1'b1, "du..");
    idle(DELAY);
    check("resend_match_vec", 64'(match_vec), 64'd1);
    check("resend_match_count", 64'(match_count), 64'd1);

    // Gapped stream.
    do_clear();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, words[i]);
      for (int g = 0; g < int'(i % 3) + 1; g++) drive(1'b0, $urandom);
    end
    idle(DELAY + 1);
    check("gap_match_vec", 64'(match_vec), 64'd1);
    check("gap_match_count", 64'(match_count), 64'd1);

    // Randomized traffic over a two-letter alphabet against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [DATA_W-1:0] w;
      if ($urandom_range(0, 99) == 0) pat_enable = 4'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        logic [MAX_LEN*8-1:0] p;
        int r;
        for (int k = 0; k < MAX_LEN; k++) p[k*8 +: 8] = $urandom_range(0, 1) ? 8'h61 : 8'h62;
        r = $urandom_range(0, 9);
        pat_wr_en   = 1'b1;
        pat_wr_idx  = 2'($urandom);
        pat_wr_data = p;
        pat_wr_len  = (r == 0) ? 5'd0 : (r == 1) ? 5'($urandom_range(17, 31)) :
                      (r == 2) ? 5'($urandom_range(7, 17)) : 5'($urandom_range(1, 5));
      end
      clear = ($urandom_range(0, 59) == 0);
      n_rst = ($urandom_range(0, 499) != 0);
      for (int k = 0; k < BPW; k++) w[k*8 +: 8] = $urandom_range(0, 1) ? 8'h61 : 8'h62;
      drive($urandom_range(0, 3) != 0, w);
    end
    n_rst = 1'b1;

    // Saturation of the event counter.
    write_pat(3, "a", 1);
    pat_enable = 4'b1000;
    do_clear();
    chk_model = 1'b0;
    for (int i = 0; i < 65540; i++) drive(1'b1, "aaaa");
    chk_model = 1'b1;
    check("sat_match_count", 64'(match_count), 64'hFFFF);
    for (int i = 0; i < 4; i++) drive(1'b1, "aaaa");
    check("sat_hold", 64'(match_count), 64'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_string_comparator.md
Name: multi_string_comparator

Overview:
Parametrised successor to the single-pattern string comparator in the packet-inspection path. It holds NUM_PAT programmable byte-string patterns and scans a DATA_W-bit payload stream for every pattern at every byte alignment, including matches that span word boundaries. Payload is forwarded through a fixed DELAY-cycle pipeline so that match flags line up with the word that completed the match. Per-pattern sticky flags, the lowest matching index and a saturating event counter feed the sniffer's flag/report logic.

Parameters:
DATA_W, 32, stream width in bits; multiple of 8; BPW = DATA_W/8 bytes per word
MAX_LEN, 17, maximum pattern length in bytes
NUM_PAT, 4, number of pattern slots
DELAY, 5, data_in to data_out latency in cycles; must be >= 1

Ports:
clk  in  1  clock, all logic on rising edge
n_rst  in  1  synchronous active-low reset
clear  in  1  flush match history, sticky flags and counter
data_valid  in  1  data_in carries a payload word this cycle
data_in  in  DATA_W  payload word; bits [DATA_W-1 -: 8] are the first byte on the wire
pat_wr_en  in  1  write a pattern slot
pat_wr_idx  in  clog2(NUM_PAT)  slot to write
pat_wr_data  in  MAX_LEN*8  pattern, right-justified: last char at [7:0], first char at byte (len-1)
pat_wr_len  in  clog2(MAX_LEN+1)  pattern length in bytes
pat_enable  in  NUM_PAT  per-slot enable
data_out  out  DATA_W  data_in delayed DELAY cycles
data_out_valid  out  1  data_valid delayed DELAY cycles
match  out  1  OR of match_vec
match_vec  out  NUM_PAT  per-slot sticky match
match_idx  out  clog2(NUM_PAT)  lowest set bit of match_vec; 0 if none
match_count  out  16  words containing at least one match, saturating

Behaviour:
- Reset (n_rst=0 at posedge): data_out, data_out_valid, match, match_vec, match_idx, match_count, history, fill counter and all pattern slots (len=0) go to 0. Reset mid-stream discards in-flight words.
- Pattern table: on pat_wr_en, slot pat_wr_idx stores data/len at posedge and its match_vec bit clears. The new pattern is used for words accepted from the next cycle on. len=0 or len>MAX_LEN: slot never matches. A disabled slot never sets its bit; an existing sticky bit stays set.
- History: byte shift register of HIST = MAX_LEN+BPW-1 bytes. On data_valid, the BPW bytes shift in first-byte-first. fill counter = valid bytes held, saturating at HIST.
- Detection, per accepted word: for each slot s and each byte position b in the word, hit when the len_s bytes ending at b equal the pattern and fill (including this word) >= len_s. Word hit for s = OR over b. Multiple hits in one word count once.
- Alignment: hits are registered, then delayed so match_vec bit s sets on the same cycle data_out presents the word that completed the match, i.e. DELAY cycles after acceptance. The bit stays set until clear, reset or a write to that slot.
- match_count increments by 1 per word with any slot hit, aligned with match_vec; it saturates at 0xFFFF.
- clear: history and fill counter zeroed; match_vec and match_count zeroed; pending hits in the alignment pipe dropped. The data pipeline and pattern table are unaffected. clear with data_valid in the same cycle: clear wins, the word is excluded from history and detection but still passes to data_out.
- clear and a newly aligned hit in the same cycle: clear wins.
- data_valid=0: history, fill counter and detection hold; data_out_valid=0 in the corresponding output cycle.
- Simultaneous pat_wr_en and an aligned hit on the same slot: the write wins and the bit stays 0.

Test Plan:
- Reset: n_rst=0 for 2 cycles with data_valid=1 -> all outputs 0; data_out_valid=0 for DELAY cycles after release.
- Boundary-spanning match: slot0="www.purdue.edu" (len 14), stream words "Host", ": ww", "w.pu", "rdue", ".edu", "\r\n\r\n" back-to-back -> data_out reproduces each word 5 cycles later. match_vec=4'b0001, match_idx=0, match_count=1 rise in the cycle data_out=".edu" and hold through the following words.
- Multi-pattern: slot2="purdue" (len 6) added to the previous case -> match_vec=4'b0101 on the ".edu" output cycle. Slot2's bit already set on the "rdue" output cycle. match_idx=0; match_count=2.
- No-false-match after reset/clear: slot1=4 bytes 0x00, feed one 0x00000000 word -> match_vec[1] sets only when fill>=4 (first word qualifies, BPW=4); with slot1 len 5, a single zero word gives no match.
- Clear priority: pulse clear together with the ".edu" word -> no match ever reported; data_out still shows ".edu" after 5 cycles; a subsequent full "www.purdue.edu" resend matches normally.
- Gapped stream and saturation: insert data_valid=0 bubbles between words of the test-2 stream -> match still detected, data_out_valid mirrors the gaps. Force 65536+ matching words -> match_count holds 0xFFFF.
